// File: rtl/uart_rx_framed.sv
// UART receiver with configurable data width, optional odd/even parity and
// 1 or 2 stop bits. Reports parity and framing errors with each word.
module uart_rx_framed #(
  parameter int unsigned CLOCKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY_MODE    = 0,
  parameter int unsigned STOP_BITS      = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 incoming_bit,
  output logic                 has_data,
  output logic [DATA_BITS-1:0] data_received,
  output logic                 parity_error,
  output logic                 framing_error
);

  localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'((CLOCKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_CLEANUP,
    S_LINE_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic                 sync_meta, sync_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_q, frm_d;
  logic                 has_data_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 perr_d, ferr_d;
  logic                 bit_done;
  logic                 parity_xor;

  // Two-flop synchroniser; idle-high so reset does not look like a start bit
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
    end else begin
      sync_meta <= incoming_bit;
      sync_q    <= sync_meta;
    end
  end

  // State, frame and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      par_err_q     <= 1'b0;
      frm_q         <= 1'b0;
      has_data      <= 1'b0;
      data_received <= '0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      par_err_q     <= par_err_d;
      frm_q         <= frm_d;
      has_data      <= has_data_d;
      data_received <= data_d;
      parity_error  <= perr_d;
      framing_error <= ferr_d;
    end
  end

  assign bit_done   = (cnt_q == CNT_LAST);
  assign parity_xor = (^shift_q) ^ sync_q;

  // Next-state, bit counting and sampling; results publish on the final stop
  // sample so has_data is high for the single CLEANUP cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_d      = frm_q;
    has_data_d = 1'b0;
    data_d     = data_received;
    perr_d     = parity_error;
    ferr_d     = framing_error;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!sync_q) begin
          state_d   = S_START;
          shift_d   = '0;
          par_err_d = 1'b0;
          frm_d     = 1'b0;
        end
      end

      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          state_d = sync_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_done) begin
          cnt_d          = '0;
          shift_d[idx_q] = sync_q;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (bit_done) begin
          cnt_d     = '0;
          state_d   = S_STOP;
          par_err_d = (PARITY_MODE == 1) ? ~parity_xor : parity_xor;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          frm_d = frm_q | ~sync_q;
          if (idx_q == STOP_LAST) begin
            idx_d      = '0;
            state_d    = S_CLEANUP;
            has_data_d = 1'b1;
            data_d     = shift_q;
            perr_d     = par_err_q;
            ferr_d     = frm_q | ~sync_q;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CLEANUP: begin
        cnt_d   = '0;
        state_d = frm_q ? S_LINE_WAIT : S_IDLE;
      end

      S_LINE_WAIT: begin
        cnt_d = '0;
        if (sync_q) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: three configurations driven from a vector table,
// results checked through per-instance expectation queues.
module tb_uart_rx_framed;

  localparam int unsigned CPB = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [2:0] line = 3'b111;

  always #5 clock = ~clock;

  // Instance 0: 8N1, instance 1: 7 bits even parity, instance 2: 8 bits odd parity 2 stop
  logic       hd_a, pe_a, fe_a;
  logic [7:0] dr_a;
  logic       hd_b, pe_b, fe_b;
  logic [6:0] dr_b;
  logic       hd_c, pe_c, fe_c;
  logic [7:0] dr_c;

  uart_rx_framed #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .clock(clock), .reset(reset), .incoming_bit(line[0]),
    .has_data(hd_a), .data_received(dr_a), .parity_error(pe_a), .framing_error(fe_a));

  uart_rx_framed #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) dut_b (
    .clock(clock), .reset(reset), .incoming_bit(line[1]),
    .has_data(hd_b), .data_received(dr_b), .parity_error(pe_b), .framing_error(fe_b));

  uart_rx_framed #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) dut_c (
    .clock(clock), .reset(reset), .incoming_bit(line[2]),
    .has_data(hd_c), .data_received(dr_c), .parity_error(pe_c), .framing_error(fe_c));

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    int         id;
    logic [8:0] data;
    bit         pflip;
    logic [1:0] stop_val;
    logic [8:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_cmp  = 0;
  int n_fail = 0;

  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned last_lat = 0;
  bit          lat_seen = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input int id, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.pe   = pe;
    e.fe   = fe;
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Compare one has_data pulse against the oldest expectation for that instance
  task automatic check_pulse(input int id, input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    bit   empty;
    e = '{default: '0};
    case (id)
      0:       begin empty = (q0.size() == 0); if (!empty) e = q0.pop_front(); end
      1:       begin empty = (q1.size() == 0); if (!empty) e = q1.pop_front(); end
      default: begin empty = (q2.size() == 0); if (!empty) e = q2.pop_front(); end
    endcase
    n_cmp++;
    if (empty) begin
      n_fail++;
      $display("FAIL unexpected_pulse dut%0d: got data=%h pe=%0b fe=%0b, required no pulse",
               id, d, pe, fe);
    end else if ({d, pe, fe} !== {e.data, e.pe, e.fe}) begin
      n_fail++;
      $display("FAIL frame dut%0d: got data=%h pe=%0b fe=%0b, required data=%h pe=%0b fe=%0b",
               id, d, pe, fe, e.data, e.pe, e.fe);
    end
    if (id == 0) begin
      last_lat = cyc - start_cyc;
      lat_seen = 1'b1;
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (!reset) begin
      if (hd_a) check_pulse(0, {1'b0, dr_a}, pe_a, fe_a);
      if (hd_b) check_pulse(1, {2'b00, dr_b}, pe_b, fe_b);
      if (hd_c) check_pulse(2, {1'b0, dr_c}, pe_c, fe_c);
    end
  end

  task automatic bit_out(input int id, input logic v);
    line[id] = v;
    repeat (CPB) @(negedge clock);
  endtask

  // Send one frame using the line format of instance id; called at a falling edge
  task automatic send_frame(input int id, input logic [8:0] data, input bit pflip,
                            input logic [1:0] stop_val, input bit hold_low);
    int   nb;
    int   pm;
    int   ns;
    logic p;
    nb = (id == 1) ? 7 : 8;
    pm = (id == 0) ? 0 : ((id == 1) ? 2 : 1);
    ns = (id == 2) ? 2 : 1;
    p  = 1'b0;
    for (int i = 0; i < nb; i++) p = p ^ data[i];
    if (pm == 1) p = ~p;
    p = p ^ pflip;
    if (id == 0) start_cyc = cyc;
    bit_out(id, 1'b0);
    for (int i = 0; i < nb; i++) bit_out(id, data[i]);
    if (pm != 0) bit_out(id, p);
    for (int i = 0; i < ns; i++) bit_out(id, stop_val[i]);
    line[id] = hold_low ? 1'b0 : 1'b1;
  endtask

  task automatic check_zero(input string name, input logic [10:0] got);
    n_cmp++;
    if (got !== 11'd0) begin
      n_fail++;
      $display("FAIL %s: got %h, required 0", name, got);
    end
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    vecs[1]  = '{1, 9'h035, 1'b0, 2'b11, 9'h035, 1'b0, 1'b0};
    vecs[2]  = '{1, 9'h035, 1'b1, 2'b11, 9'h035, 1'b1, 1'b0};
    vecs[3]  = '{1, 9'h07F, 1'b0, 2'b11, 9'h07F, 1'b0, 1'b0};
    vecs[4]  = '{1, 9'h000, 1'b1, 2'b11, 9'h000, 1'b1, 1'b0};
    vecs[5]  = '{1, 9'h012, 1'b0, 2'b10, 9'h012, 1'b0, 1'b1};
    vecs[6]  = '{2, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
    vecs[7]  = '{2, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
    vecs[8]  = '{2, 9'h055, 1'b0, 2'b01, 9'h055, 1'b0, 1'b1};
    vecs[9]  = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
    vecs[10] = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};

    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check_zero("reset_dut0", {hd_a, 1'b0, dr_a, pe_a});
    check_zero("reset_dut1", {hd_b, 2'b00, dr_b, fe_b, pe_b});
    check_zero("reset_dut2", {hd_c, dr_c, pe_c, fe_c});

    // Vector table; instance 2 frames go out back to back with no idle gap
    for (int i = 0; i < 11; i++) begin
      push(vecs[i].id, vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe);
      send_frame(vecs[i].id, vecs[i].data, vecs[i].pflip, vecs[i].stop_val, 1'b0);
      if (i == 0) begin
        n_cmp++;
        if (!lat_seen || last_lat < 154 || last_lat > 156) begin
          n_fail++;
          $display("FAIL latency: got %0d clocks (seen=%0b), required 155 +/-1", last_lat, lat_seen);
        end
      end
    end
    repeat (2 * CPB) @(negedge clock);

    // Short low glitch on an idle line, then a real frame
    line[0] = 1'b0;
    repeat (5) @(negedge clock);
    line[0] = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    push(0, 9'h081, 1'b0, 1'b0);
    send_frame(0, 9'h081, 1'b0, 2'b11, 1'b0);
    repeat (CPB) @(negedge clock);

    // Framing error followed by a 30-bit break; exactly one pulse expected
    push(0, 9'h05A, 1'b0, 1'b1);
    send_frame(0, 9'h05A, 1'b0, 2'b00, 1'b1);
    repeat (30 * CPB) @(negedge clock);
    line[0] = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    push(0, 9'h03C, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b0);
    repeat (CPB) @(negedge clock);

    // One-clock reset in the middle of the data bits of 0xFF
    fork
      send_frame(0, 9'h0FF, 1'b0, 2'b11, 1'b0);
      begin
        repeat (3 * CPB) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
    join
    check_zero("after_reset_dut0", {hd_a, 1'b0, dr_a, pe_a});
    check_zero("after_reset_fe_dut0", {10'd0, fe_a});
    repeat (CPB) @(negedge clock);
    push(0, 9'h00F, 1'b0, 1'b0);
    send_frame(0, 9'h00F, 1'b0, 2'b11, 1'b0);

    // Let outstanding expectations drain, bounded
    for (int k = 0; k < 8 * CPB && (q0.size() + q1.size() + q2.size()) != 0; k++)
      @(negedge clock);
    repeat (4 * CPB) @(negedge clock);

    n_cmp++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: got %0d/%0d/%0d frames still outstanding, required 0/0/0",
               q0.size(), q1.size(), q2.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
